// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the button pattern sequencer: FSM state encoding
// and the LED one-hot helper.
package pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int ONEHOT_W = 32;

    // Callers slice the low NUM_BTN bits of the result.
    function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/pattern_sequencer_seq_timer.sv
// Step/gap interval timer: counts while enabled and flags the cycle where the
// count reaches the selected limit, restarting from zero after it.
module seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    assign done = en && (cnt_r == limit);

    // Interval counter; clear dominates, wraps to zero on reaching the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= done ? '0 : cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Records debounced button presses into a small sequence memory and plays the
// recorded order back on the LEDs, one lit step followed by a dark gap.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int CNT_W       = 24,
    parameter int STEP_CYCLES = 6000000 - 1,
    parameter int GAP_CYCLES  = 1200000 - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_pulse,
    input  logic               play_pulse,
    input  logic               clear_pulse,
    output logic [NUM_BTN-1:0] led,
    output logic               busy,
    output logic               full,
    output logic [ADDR_W:0]    count
);

    localparam int               IDX_W    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);

    state_e              state_r, state_s;
    logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]     count_r, count_s;
    logic [NUM_BTN-1:0]  led_r, led_s;
    logic                busy_r;
    logic [IDX_W-1:0]    mem_r [DEPTH];

    logic                wr_en_s;
    logic [IDX_W-1:0]    btn_idx_s;
    logic                btn_any_s;
    logic                full_s;
    logic                last_step_s;
    logic                tmr_clr_s, tmr_en_s, tmr_done_s;
    logic [CNT_W-1:0]    tmr_limit_s;
    logic [ONEHOT_W-1:0] oh_s;

    assign full_s      = (count_r == DEPTH_C);
    assign btn_any_s   = |btn_pulse;
    assign last_step_s = ({1'b0, rd_ptr_r} == (count_r - 1'b1));

    // Lowest-index pressed button wins when several pulse together.
    always_comb begin
        btn_idx_s = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            btn_idx_s = btn_pulse[i] ? IDX_W'(i) : btn_idx_s;
        end
    end

    // Timer runs only during playback; an abort clears it alongside the FSM.
    always_comb begin
        tmr_en_s    = (state_r != ST_IDLE);
        tmr_clr_s   = (state_r == ST_IDLE) || clear_pulse;
        tmr_limit_s = (state_r == ST_SHOW) ? STEP_LIM : GAP_LIM;
    end

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .limit (tmr_limit_s),
        .done  (tmr_done_s)
    );

    // Next-state, pointer and count logic; clear > play > button.
    always_comb begin
        state_s  = state_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        wr_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear_pulse) begin
                    count_s = '0;
                end else if (play_pulse) begin
                    if (count_r != '0) begin
                        state_s  = ST_SHOW;
                        rd_ptr_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (btn_any_s && !full_s) begin
                    wr_en_s = 1'b1;
                    count_s = count_r + 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_SHOW: begin
                if (clear_pulse) begin
                    state_s  = ST_IDLE;
                    rd_ptr_s = '0;
                    count_s  = '0;
                end else if (tmr_done_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_GAP: begin
                if (clear_pulse) begin
                    state_s  = ST_IDLE;
                    rd_ptr_s = '0;
                    count_s  = '0;
                end else if (tmr_done_s) begin
                    if (last_step_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s  = ST_SHOW;
                        rd_ptr_s = rd_ptr_r + 1'b1;
                    end
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                rd_ptr_s = '0;
                count_s  = '0;
            end
        endcase
    end

    // LED value for the coming cycle, so the output is a plain register.
    always_comb begin
        oh_s  = onehot(5'(mem_r[rd_ptr_s]));
        led_s = (state_s == ST_SHOW) ? oh_s[NUM_BTN-1:0] : '0;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rd_ptr_r <= '0;
            count_r  <= '0;
            led_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
            led_r    <= led_s;
            busy_r   <= (state_s != ST_IDLE);
        end
    end

    // Sequence memory; contents survive clear, only the count is reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[count_r[ADDR_W-1:0]] <= btn_idx_s;
        end
    end

    assign led   = led_r;
    assign busy  = busy_r;
    assign full  = full_s;
    assign count = count_r;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: table-driven vectors plus
// hand-written corner sequences, expectations flow through a scoreboard queue.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_pulse;
    logic       play_pulse;
    logic       clear_pulse;
    logic [3:0] led;
    logic       busy;
    logic       full;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] btn;
        logic       play;
        logic       clr;
        logic [3:0] led;
        logic       busy;
        logic [2:0] count;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] led;
        logic       busy;
        logic [2:0] count;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    exp_t mon_e;

    pattern_sequencer #(
        .NUM_BTN     (4),
        .DEPTH       (4),
        .ADDR_W      (2),
        .CNT_W       (4),
        .STEP_CYCLES (3),
        .GAP_CYCLES  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_pulse   (btn_pulse),
        .play_pulse  (play_pulse),
        .clear_pulse (clear_pulse),
        .led         (led),
        .busy        (busy),
        .full        (full),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, ".led"},   32'(led),   32'(mon_e.led));
            chk({mon_e.name, ".busy"},  32'(busy),  32'(mon_e.busy));
            chk({mon_e.name, ".count"}, 32'(count), 32'(mon_e.count));
            chk({mon_e.name, ".full"},  32'(full),  32'(mon_e.count == 3'd4));
        end
    end

    task automatic cyc(input logic [3:0] b, input logic p, input logic c,
                       input logic [3:0] el, input logic eb, input logic [2:0] ec,
                       input string nm);
        exp_t e;
        @(negedge clk);
        btn_pulse   = b;
        play_pulse  = p;
        clear_pulse = c;
        e.led = el; e.busy = eb; e.count = ec; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic add(input logic [3:0] b, input logic p, input logic c,
                       input logic [3:0] el, input logic eb, input logic [2:0] ec,
                       input string nm);
        vec_t v;
        v.btn = b; v.play = p; v.clr = c;
        v.led = el; v.busy = eb; v.count = ec; v.name = nm;
        tbl.push_back(v);
    endtask

    // Playback expectation: 4 lit cycles then 2 dark per step, then idle.
    task automatic add_play(input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] s3,
                            input int nsteps, input logic [2:0] cnt,
                            input logic [3:0] first_btn, input string nm);
        logic [3:0] steps [4];
        steps[0] = s0; steps[1] = s1; steps[2] = s2; steps[3] = s3;
        for (int s = 0; s < nsteps; s++) begin
            for (int k = 0; k < 6; k++) begin
                add((s == 0 && k == 0) ? first_btn : 4'b0000,
                    (s == 0 && k == 0), 1'b0,
                    (k < 4) ? steps[s] : 4'b0000, 1'b1, cnt,
                    $sformatf("%s_s%0d_c%0d", nm, s, k));
            end
        end
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, cnt, {nm, "_idle"});
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain act=%0d exp=0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_pulse = 4'b0000;
        play_pulse = 1'b0;
        clear_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.led",   32'(led),   32'h0);
        chk("reset.busy",  32'(busy),  32'h0);
        chk("reset.count", 32'(count), 32'h0);
        chk("reset.full",  32'(full),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Record and play.
        add(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, "rec0");
        add(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, "rec1");
        add(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd3, "rec2");
        add_play(4'b0100, 4'b0001, 4'b1000, 4'b0000, 3, 3'd3, 4'b0000, "play3");
        // Overflow.
        add(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, "ovf_clr");
        for (int i = 0; i < 5; i++) begin
            add(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, (i < 4) ? 3'(i + 1) : 3'd4,
                $sformatf("ovf_btn%0d", i));
        end
        add_play(4'b0010, 4'b0010, 4'b0010, 4'b0010, 4, 3'd4, 4'b0000, "ovf_play");
        // Simultaneous and empty.
        add(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, "sim_clr");
        add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, "empty_play");
        add(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, "multi_btn");
        add_play(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 3'd1, 4'b0001, "play_btn");

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].btn, tbl[i].play, tbl[i].clr,
                tbl[i].led, tbl[i].busy, tbl[i].count, tbl[i].name);
        end
        wait_drain("table");

        // Abort during the second SHOW step.
        cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, "ab_clr");
        cyc(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, "ab_rec0");
        cyc(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, "ab_rec1");
        for (int k = 0; k < 7; k++) begin
            cyc(4'b0000, (k == 0), 1'b0,
                (k < 4) ? 4'b0001 : ((k < 6) ? 4'b0000 : 4'b0010), 1'b1, 3'd2,
                $sformatf("ab_play%0d", k));
        end
        cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, "ab_abort");
        cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, "ab_play_ignored");
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, "ab_idle");

        // Button and play pulses during GAP are ignored.
        cyc(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, "ig_rec0");
        cyc(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, "ig_rec1");
        for (int k = 0; k < 12; k++) begin
            cyc((k == 4) ? 4'b0001 : 4'b0000, (k == 0) || (k == 4), 1'b0,
                (k < 4) ? 4'b1000 : ((k >= 6 && k < 10) ? 4'b0100 : 4'b0000),
                1'b1, 3'd2, $sformatf("ig_play%0d", k));
        end
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, "ig_idle");

        // Asynchronous reset in the middle of a SHOW step.
        cyc(4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd2, "ar_play");
        cyc(4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 3'd2, "ar_show");
        wait_drain("ar");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.led",   32'(led),   32'h0);
        chk("ar.busy",  32'(busy),  32'h0);
        chk("ar.count", 32'(count), 32'h0);
        chk("ar.full",  32'(full),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, "ar_after");
        cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, "ar_after2");
        wait_drain("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
